// File: rtl/alu_pkg.sv
// Shared opcodes, default widths/latencies and the multiply/divide unit state type
// for the EX-stage ALU with its iterative multiply/divide unit.
package alu_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_MUL_CYCLES = 5;
  localparam int DEF_DIV_CYCLES = 10;

  // The first four keep the legacy combinational ALU encodings.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_OR   = 4'd2;
  localparam logic [3:0] ALU_EQ   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_NOR  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SRA  = 4'd11;
  localparam logic [3:0] ALU_LUI  = 4'd12;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;
  localparam logic [2:0] MD_RSVD  = 3'd7;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative-latency multiply/divide unit: results are computed at accept time into
// pending registers and committed to HI/LO when the busy countdown expires.
module md_unit
  import alu_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       md_op,
  input  logic             md_start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = max_int(MUL_CYCLES, DIV_CYCLES);
  localparam int CW         = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  md_state_t        state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] hi_reg, hi_next, lo_reg, lo_next;
  logic [WIDTH-1:0] pend_hi_reg, pend_hi_next, pend_lo_reg, pend_lo_next;
  logic             pend_wr_reg, pend_wr_next;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               div_zero;
  logic [WIDTH-1:0]   divisor_u, mag_a, mag_b, mag_b_safe;
  logic [WIDTH-1:0]   quo_u, rem_u, quo_m, rem_m, quo_s, rem_s;

  // Signed division runs on magnitudes so MIN / -1 wraps to MIN with a zero remainder.
  always_comb begin
    prod_s     = {{WIDTH{in1[WIDTH-1]}}, in1} * {{WIDTH{in2[WIDTH-1]}}, in2};
    prod_u     = {{WIDTH{1'b0}}, in1} * {{WIDTH{1'b0}}, in2};
    div_zero   = (in2 == '0);
    divisor_u  = div_zero ? WIDTH'(1) : in2;
    quo_u      = in1 / divisor_u;
    rem_u      = in1 % divisor_u;
    mag_a      = in1[WIDTH-1] ? -in1 : in1;
    mag_b      = in2[WIDTH-1] ? -in2 : in2;
    mag_b_safe = div_zero ? WIDTH'(1) : mag_b;
    quo_m      = mag_a / mag_b_safe;
    rem_m      = mag_a % mag_b_safe;
    quo_s      = (in1[WIDTH-1] ^ in2[WIDTH-1]) ? -quo_m : quo_m;
    rem_s      = in1[WIDTH-1] ? -rem_m : rem_m;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= MD_IDLE;
      cnt_reg     <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      pend_hi_reg <= '0;
      pend_lo_reg <= '0;
      pend_wr_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      pend_hi_reg <= pend_hi_next;
      pend_lo_reg <= pend_lo_next;
      pend_wr_reg <= pend_wr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    pend_hi_next = pend_hi_reg;
    pend_lo_next = pend_lo_reg;
    pend_wr_next = pend_wr_reg;
    case (state_reg)
      MD_IDLE: begin
        if (md_start) begin
          case (md_op)
            MD_MULT: begin
              pend_hi_next = prod_s[2*WIDTH-1:WIDTH];
              pend_lo_next = prod_s[WIDTH-1:0];
              pend_wr_next = 1'b1;
              cnt_next     = MUL_LOAD;
              state_next   = MD_BUSY;
            end
            MD_MULTU: begin
              pend_hi_next = prod_u[2*WIDTH-1:WIDTH];
              pend_lo_next = prod_u[WIDTH-1:0];
              pend_wr_next = 1'b1;
              cnt_next     = MUL_LOAD;
              state_next   = MD_BUSY;
            end
            // A zero divisor still occupies the unit but never commits.
            MD_DIV: begin
              pend_hi_next = rem_s;
              pend_lo_next = quo_s;
              pend_wr_next = !div_zero;
              cnt_next     = DIV_LOAD;
              state_next   = MD_BUSY;
            end
            MD_DIVU: begin
              pend_hi_next = rem_u;
              pend_lo_next = quo_u;
              pend_wr_next = !div_zero;
              cnt_next     = DIV_LOAD;
              state_next   = MD_BUSY;
            end
            MD_MTHI: hi_next = in1;
            MD_MTLO: lo_next = in1;
            MD_NONE, MD_RSVD: ;
          endcase
        end
      end
      MD_BUSY: begin
        if (cnt_reg == '0) begin
          state_next = MD_IDLE;
          if (pend_wr_reg) begin
            hi_next = pend_hi_reg;
            lo_next = pend_lo_reg;
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: state_next = MD_IDLE;
    endcase
  end

  assign busy = (state_reg == MD_BUSY);
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: rtl/alu_md.sv
// EX-stage ALU: combinational result/flags path plus the multiply/divide unit
// holding architectural HI/LO.
module alu_md
  import alu_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             overflow,
  input  logic [2:0]       md_op,
  input  logic             md_start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum, diff;

  assign shamt = in1[SHW-1:0];
  assign sum   = in1 + in2;
  assign diff  = in1 - in2;

  // Overflow only when the result sign disagrees with what the operand signs allow.
  always_comb begin
    alu_out  = '0;
    overflow = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        alu_out  = sum;
        overflow = (in1[MSB] == in2[MSB]) && (sum[MSB] != in1[MSB]);
      end
      ALU_SUB: begin
        alu_out  = diff;
        overflow = (in1[MSB] != in2[MSB]) && (diff[MSB] != in1[MSB]);
      end
      ALU_OR:   alu_out = in1 | in2;
      ALU_EQ:   alu_out = WIDTH'(in1 == in2);
      ALU_AND:  alu_out = in1 & in2;
      ALU_XOR:  alu_out = in1 ^ in2;
      ALU_NOR:  alu_out = ~(in1 | in2);
      ALU_SLT:  alu_out = WIDTH'($signed(in1) < $signed(in2));
      ALU_SLTU: alu_out = WIDTH'(in1 < in2);
      ALU_SLL:  alu_out = in2 << shamt;
      ALU_SRL:  alu_out = in2 >> shamt;
      ALU_SRA:  alu_out = $unsigned($signed(in2) >>> shamt);
      ALU_LUI:  alu_out = in2 << (WIDTH / 2);
      default:  alu_out = '0;
    endcase
  end

  assign zero = (alu_out == '0);

  md_unit #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_unit (
    .clk      (clk),
    .reset_n  (reset_n),
    .md_op    (md_op),
    .md_start (md_start),
    .in1      (in1),
    .in2      (in2),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

endmodule

// File: tb/tb_alu_md.sv
// Randomized bench for alu_md at WIDTH=32 (default latencies) and WIDTH=16 (1/3 cycles),
// checked against an arithmetic reference model of the ALU and HI/LO.
module tb_alu_md;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [3:0]  alu_op32, alu_op16;
  logic [31:0] in1_32, in2_32, out32, hi32, lo32;
  logic [15:0] in1_16, in2_16, out16, hi16, lo16;
  logic        zero32, ovf32, busy32, start32;
  logic        zero16, ovf16, busy16, start16;
  logic [2:0]  md_op32, md_op16;

  logic [31:0] exp_hi32, exp_lo32, exp_hi16, exp_lo16;
  int n_cmp = 0;
  int n_bad = 0;

  alu_md dut32 (
    .clk(clk), .reset_n(reset_n), .alu_op(alu_op32), .in1(in1_32), .in2(in2_32),
    .alu_out(out32), .zero(zero32), .overflow(ovf32), .md_op(md_op32),
    .md_start(start32), .busy(busy32), .hi(hi32), .lo(lo32)
  );

  alu_md #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) dut16 (
    .clk(clk), .reset_n(reset_n), .alu_op(alu_op16), .in1(in1_16), .in2(in2_16),
    .alu_out(out16), .zero(zero16), .overflow(ovf16), .md_op(md_op16),
    .md_start(start16), .busy(busy16), .hi(hi16), .lo(lo16)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ALU reference: integer arithmetic on 64-bit values; returns {overflow, result}.
  function automatic logic [32:0] ref_alu32(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ub, r, p, lim;
    logic [31:0] res;
    logic ov;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'(b);
    p   = longint'(1) << int'(a[4:0]);
    lim = longint'(1) << 31;
    ov  = 1'b0;
    r   = 0;
    case (op)
      4'd0:  begin r = sa + sb; ov = (r >= lim) || (r < -lim); end
      4'd1:  begin r = sa - sb; ov = (r >= lim) || (r < -lim); end
      4'd2:  r = longint'(a | b);
      4'd3:  r = (a == b) ? 1 : 0;
      4'd4:  r = longint'(a & b);
      4'd5:  r = longint'(a ^ b);
      4'd6:  r = longint'(~(a | b));
      4'd7:  r = (sa < sb) ? 1 : 0;
      4'd8:  r = (longint'(a) < ub) ? 1 : 0;
      4'd9:  r = ub * p;
      4'd10: r = ub / p;
      4'd11: r = (sb >= 0) ? sb / p : -((-sb + p - 1) / p);
      4'd12: r = ub * 65536;
      default: r = 0;
    endcase
    res = r[31:0];
    return {ov, res};
  endfunction

  // HI/LO reference for a w-bit unit; eh/el carry the architectural state in and out.
  task automatic ref_md(input int w, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, inout logic [31:0] eh, inout logic [31:0] el);
    longint mask, ua, ub, sa, sb, p, q, r;
    mask = (longint'(1) << w) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = a[w-1] ? ua - (longint'(1) << w) : ua;
    sb = b[w-1] ? ub - (longint'(1) << w) : ub;
    case (op)
      MD_MULT:  begin p = sa * sb; eh = 32'((p >> w) & mask); el = 32'(p & mask); end
      MD_MULTU: begin p = ua * ub; eh = 32'((p >> w) & mask); el = 32'(p & mask); end
      MD_DIV:   if (ub != 0) begin
                  q = sa / sb; r = sa % sb; el = 32'(q & mask); eh = 32'(r & mask);
                end
      MD_DIVU:  if (ub != 0) begin
                  q = ua / ub; r = ua % ub; el = 32'(q & mask); eh = 32'(r & mask);
                end
      MD_MTHI:  eh = 32'(ua);
      MD_MTLO:  el = 32'(ua);
      default: ;
    endcase
  endtask

  function automatic logic [31:0] cur_hi(input int w);
    return (w == 32) ? hi32 : {16'b0, hi16};
  endfunction
  function automatic logic [31:0] cur_lo(input int w);
    return (w == 32) ? lo32 : {16'b0, lo16};
  endfunction
  function automatic logic cur_busy(input int w);
    return (w == 32) ? busy32 : busy16;
  endfunction

  task automatic alu_exp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eo, input logic ev, input string tag);
    alu_op32 = op; in1_32 = a; in2_32 = b;
    #1;
    check_val({tag, " out"}, 64'(out32), 64'(eo));
    check_val({tag, " zero"}, 64'(zero32), 64'(eo == 32'd0));
    check_val({tag, " ovf"}, 64'(ovf32), 64'(ev));
    $display("txn alu %s op=%0d a=%h b=%h out=%h", tag, op, a, b, out32);
  endtask

  task automatic alu_rand(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] e;
    e = ref_alu32(op, a, b);
    alu_exp(op, a, b, e[31:0], e[32], "alu rand");
  endtask

  task automatic md_txn(input int w, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    logic [31:0] eh, el, oh, ol;
    int n_exp, n_busy;
    eh = (w == 32) ? exp_hi32 : exp_hi16;
    el = (w == 32) ? exp_lo32 : exp_lo16;
    oh = eh;
    ol = el;
    ref_md(w, op, a, b, eh, el);
    if (op == MD_MULT || op == MD_MULTU) n_exp = (w == 32) ? 5 : 1;
    else if (op == MD_DIV || op == MD_DIVU) n_exp = (w == 32) ? 10 : 3;
    else n_exp = 0;
    @(negedge clk);
    if (w == 32) begin
      md_op32 = op; in1_32 = a; in2_32 = b; start32 = 1'b1;
    end else begin
      md_op16 = op; in1_16 = a[15:0]; in2_16 = b[15:0]; start16 = 1'b1;
    end
    @(negedge clk);
    start32 = 1'b0;
    start16 = 1'b0;
    if (n_exp > 0) begin
      check_val({tag, " hold hi"}, 64'(cur_hi(w)), 64'(oh));
      check_val({tag, " hold lo"}, 64'(cur_lo(w)), 64'(ol));
    end
    n_busy = 0;
    while (cur_busy(w) && n_busy < 200) begin
      n_busy++;
      @(negedge clk);
    end
    check_val({tag, " busy cycles"}, 64'(n_busy), 64'(n_exp));
    check_val({tag, " hi"}, 64'(cur_hi(w)), 64'(eh));
    check_val({tag, " lo"}, 64'(cur_lo(w)), 64'(el));
    if (w == 32) begin exp_hi32 = eh; exp_lo32 = el; end
    else begin exp_hi16 = eh; exp_lo16 = el; end
    $display("txn md%0d %s op=%0d a=%h b=%h busy=%0d hi=%h lo=%h", w, tag, op, a, b,
             n_busy, cur_hi(w), cur_lo(w));
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] pick16();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000;
      2: return 32'hFFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n_wait;
    reset_n = 1'b0;
    alu_op32 = '0; alu_op16 = '0; in1_32 = '0; in2_32 = '0; in1_16 = '0; in2_16 = '0;
    exp_hi32 = '0; exp_lo32 = '0; exp_hi16 = '0; exp_lo16 = '0;

    // Start strobe held during reset must not take effect.
    md_op32 = MD_MULT; in1_32 = 32'd3; in2_32 = 32'd7; start32 = 1'b1;
    md_op16 = MD_MULT; in1_16 = 16'd3; in2_16 = 16'd7; start16 = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst busy", 64'(busy32), 64'(0));
    check_val("rst hi", 64'(hi32), 64'(0));
    check_val("rst lo", 64'(lo32), 64'(0));
    start32 = 1'b0; start16 = 1'b0; md_op32 = MD_NONE; md_op16 = MD_NONE;
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check_val("post rst busy", 64'(busy32), 64'(0));
    check_val("post rst hi", 64'(hi32), 64'(0));
    check_val("post rst lo", 64'(lo32), 64'(0));
    check_val("post rst lo16", 64'(lo16), 64'(0));

    // Reset mid-operation aborts without a late write.
    md_op32 = MD_MULT; in1_32 = 32'd3; in2_32 = 32'd7; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_val("abort busy", 64'(busy32), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check_val("abort hi", 64'(hi32), 64'(0));
    check_val("abort lo", 64'(lo32), 64'(0));
    $display("txn reset abort done");

    // ALU directed vectors
    alu_exp(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1, "add ovf");
    alu_exp(ALU_SUB, 32'd5, 32'd5, 32'h0, 1'b0, "sub zero");
    alu_exp(ALU_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1, "sub ovf");
    alu_exp(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, "slt");
    alu_exp(ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, "sltu");
    alu_exp(ALU_SRA, 32'd4, 32'h8000_0000, 32'hF800_0000, 1'b0, "sra");
    alu_exp(ALU_LUI, 32'h0, 32'h1234, 32'h1234_0000, 1'b0, "lui");
    alu_exp(ALU_EQ, 32'hABCD, 32'hABCD, 32'h1, 1'b0, "eq");
    alu_exp(4'd13, 32'h1, 32'h2, 32'h0, 1'b0, "op13");

    for (int i = 0; i < 300; i++) begin
      alu_rand(4'($urandom_range(0, 15)), pick32(), pick32());
    end

    // Multiply/divide directed at WIDTH=32
    md_txn(32, MD_MULT, 32'hFFFF_FFFD, 32'd7, "mult -3x7");
    check_val("mult hi lit", 64'(hi32), 64'h0000_0000_FFFF_FFFF);
    check_val("mult lo lit", 64'(lo32), 64'h0000_0000_FFFF_FFEB);
    md_txn(32, MD_MULTU, 32'hFFFF_FFFF, 32'd2, "multu");
    check_val("multu hi lit", 64'(hi32), 64'h1);
    check_val("multu lo lit", 64'(lo32), 64'hFFFF_FFFE);
    md_txn(32, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div min/-1");
    check_val("divmin lo lit", 64'(lo32), 64'h8000_0000);
    check_val("divmin hi lit", 64'(hi32), 64'h0);
    md_txn(32, MD_DIV, 32'hFFFF_FFF9, 32'd2, "div -7/2");
    check_val("div lo lit", 64'(lo32), 64'hFFFF_FFFD);
    check_val("div hi lit", 64'(hi32), 64'hFFFF_FFFF);
    md_txn(32, MD_DIVU, 32'h1234, 32'd0, "divu x/0");
    check_val("div0 lo lit", 64'(lo32), 64'hFFFF_FFFD);

    // Collision: mtlo while busy is dropped; mthi right after busy falls is taken.
    @(negedge clk);
    md_op32 = MD_MULT; in1_32 = 32'd6; in2_32 = 32'd7; start32 = 1'b1;
    @(negedge clk);
    md_op32 = MD_MTLO; in1_32 = 32'hAA; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    n_wait = 0;
    while (busy32 && n_wait < 50) begin
      n_wait++;
      @(negedge clk);
    end
    check_val("coll busy bound", 64'(n_wait < 50), 64'(1));
    check_val("coll lo", 64'(lo32), 64'd42);
    check_val("coll hi", 64'(hi32), 64'd0);
    md_op32 = MD_MTHI; in1_32 = 32'h55; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    check_val("mthi hi", 64'(hi32), 64'h55);
    check_val("mthi busy", 64'(busy32), 64'(0));
    check_val("mthi lo", 64'(lo32), 64'd42);
    exp_hi32 = 32'h55; exp_lo32 = 32'd42;
    $display("txn collision done hi=%h lo=%h", hi32, lo32);

    // Random sweep at WIDTH=16 plus a few at WIDTH=32
    for (int i = 0; i < 80; i++) begin
      md_txn(16, 3'($urandom_range(0, 7)), pick16(), pick16(), "rand16");
    end
    for (int i = 0; i < 20; i++) begin
      md_txn(32, 3'($urandom_range(0, 7)), pick32(), pick32(), "rand32");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Parametrised successor to the CPU's combinational ALU, for the pipelined datapath.
- Keeps the four legacy ALU operations with their original encodings and adds logic, compare, shift and lui operations, plus signed-overflow and zero flags.
- Adds an iterative multiply/divide unit with architectural HI/LO registers and a busy handshake.
- Sits in the EX stage. The hazard unit stalls on busy.

Parameters:
- WIDTH, 32, datapath width; must be even and at least 8.
- MUL_CYCLES, 5, busy cycles for mult/multu; must be at least 1.
- DIV_CYCLES, 10, busy cycles for div/divu; must be at least 1.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- alu_op  in  4  ALU operation select.
- in1  in  WIDTH  operand A (rs); also the shift amount for shifts.
- in2  in  WIDTH  operand B (rt/imm); the shifted value for shifts.
- alu_out  out  WIDTH  combinational ALU result.
- zero  out  1  high when alu_out == 0.
- overflow  out  1  signed overflow flag for add/sub; 0 for every other operation.
- md_op  in  3  multiply/divide operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 is treated as none.
- md_start  in  1  request strobe, qualified by md_op.
- busy  out  1  multiply/divide operation in progress.
- hi  out  WIDTH  registered HI.
- lo  out  WIDTH  registered LO.

Behaviour:
- ALU path is purely combinational.
  - alu_op 0 add; 1 sub; 2 or; 3 eq (1 if in1 == in2, else 0). These match the legacy encodings.
  - alu_op 4 and; 5 xor; 6 nor.
  - alu_op 7 slt (signed); 8 sltu. Compare results are zero-extended 0/1.
  - alu_op 9 sll, 10 srl, 11 sra: in2 is shifted by in1[$clog2(WIDTH)-1:0].
  - alu_op 12 lui: in2 << (WIDTH/2).
  - alu_op 13-15: alu_out = 0.
  - Add and sub wrap modulo 2^WIDTH. overflow is computed from the operand and result sign bits.
- Reset: hi=0, lo=0, busy=0, counter=0, pending results cleared. Reset asserted mid-operation aborts the operation and no HI/LO write occurs.
- Accept condition: md_start && !busy at a rising edge.
  - md_start while busy is ignored: no queuing, no error.
  - md_start with md_op 0 or 7 does nothing.
- mthi/mtlo: hi (or lo) <= in1 on the accepting edge. Visible the next cycle. busy stays 0.
- mult/multu/div/divu, on the accepting edge:
  - Operands are captured.
  - The full 2*WIDTH product, or quotient and remainder, is computed into pending registers.
  - The counter is loaded with N-1, where N = MUL_CYCLES or DIV_CYCLES; busy <= 1.
  - Each later edge decrements the counter. On the edge where the counter is 0, hi/lo <= pending and busy <= 0.
  - busy is therefore high for exactly N cycles. hi/lo hold their old values until busy falls.
- mult/multu: hi = upper WIDTH bits of the product, lo = lower WIDTH bits. Operands are sign-extended (mult) or zero-extended (multu).
- div/divu: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Signed MIN / -1: lo = MIN, hi = 0.
  - Divide by zero: busy runs the full DIV_CYCLES, then hi and lo are left unchanged.
- Back-to-back: a new md_start may be accepted in the first cycle busy is 0.
- Pending registers hold their value between operations and are not visible on any output.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_* opcode localparams (4-bit);
  - MD_* opcode localparams (3-bit);
  - default widths and latencies.
- One natural sub-module: md_unit. It owns the counter, pending registers, HI/LO and busy. The top level instantiates the ALU case logic and md_unit.

Test Plan:
- Reset: hold reset_n=0, start a mult, then release -> hi=lo=0, busy=0, and no late write after release.
- ALU directed vectors, WIDTH=32:
  - add 0x7FFFFFFF+1 -> 0x80000000, overflow=1;
  - sub 5-5 -> 0, zero=1;
  - slt -1<1 -> 1, while sltu -> 0;
  - sra 0x80000000 by 4 -> 0xF8000000;
  - lui 0x1234 -> 0x12340000.
- mult timing: mult -3 x 7 with MUL_CYCLES=5 -> busy high exactly 5 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFEB on the falling busy edge; multu 0xFFFFFFFF x 2 -> hi=1, lo=0xFFFFFFFE.
- div cases:
  - div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF;
  - div 0x80000000 / -1 -> lo=0x80000000, hi=0;
  - divu x/0 -> hi and lo unchanged after 10 busy cycles.
- Collisions: md_start (mtlo 0xAA) during busy is ignored, lo keeps the operation result. mthi 0x55 on the first non-busy cycle -> hi=0x55 next cycle, busy stays 0.
- Parameter sweep at WIDTH=16, MUL_CYCLES=1, DIV_CYCLES=3: random signed/unsigned mult/div compared against a reference model, with busy length checked on every operation.
